// File: rtl/csi2_packet_tx.sv
// csi2_packet_tx: 2-lane CSI-2 framer emitting FS, per-line long packets and FE as registered HS byte pairs
module csi2_packet_tx #(
    parameter int         WORD_COUNT = 640,
    parameter int         LINES      = 480,
    parameter logic [5:0] DATA_TYPE  = 6'h2A,
    parameter logic [1:0] VC         = 2'd0,
    parameter int         LINE_GAP   = 16,
    parameter int         FRAME_GAP  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [15:0] lane_data,
    output logic        lane_hs,
    output logic        frame_act,
    output logic [15:0] frame_num,
    output logic        underrun
);
    localparam logic [15:0] WC_LINE   = 16'(WORD_COUNT);
    localparam logic [15:0] LAST_BEAT = 16'(WORD_COUNT / 2 - 1);
    localparam logic [15:0] LAST_LINE = 16'(LINES - 1);
    localparam logic [15:0] LAST_LGAP = 16'(LINE_GAP - 1);
    localparam logic [15:0] LAST_FGAP = 16'(FRAME_GAP - 1);

    typedef enum logic [2:0] {IDLE, SYNC, HDR0, HDR1, PAYLOAD, CRC, GAP} state_t;
    typedef enum logic [1:0] {PKT_FS, PKT_LINE, PKT_FE} pkt_t;

    state_t      state;
    pkt_t        pkt;
    logic [15:0] line_cnt, cnt, crc, wc, beat, crc_next, frame_inc;
    logic [7:0]  di, ecc;
    logic        gap_done;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? (r >> 1) ^ 16'h8408 : r >> 1;
        return r;
    endfunction

    // Each mask selects the header bits feeding one Hamming parity bit P0..P5
    function automatic logic [7:0] ecc_of(input logic [23:0] d);
        return {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    endfunction

    assign di        = {VC, pkt == PKT_LINE ? DATA_TYPE : {5'd0, pkt == PKT_FE}};
    assign wc        = pkt == PKT_LINE ? WC_LINE : frame_num;
    assign ecc       = ecc_of({wc, di});
    assign beat      = pix_valid ? pix_data : 16'h0000;
    assign crc_next  = crc_byte(crc_byte(crc, beat[7:0]), beat[15:8]);
    assign frame_inc = frame_num == 16'hFFFF ? 16'h0001 : frame_num + 16'd1;
    assign gap_done  = cnt == (pkt == PKT_FE ? LAST_FGAP : LAST_LGAP);
    assign pix_ready = state == PAYLOAD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pkt       <= PKT_FS;
            line_cnt  <= '0;
            cnt       <= '0;
            crc       <= 16'hFFFF;
            lane_data <= '0;
            lane_hs   <= 1'b0;
            frame_act <= 1'b0;
            frame_num <= '0;
            underrun  <= 1'b0;
        end else begin
            lane_hs   <= state inside {SYNC, HDR0, HDR1, PAYLOAD, CRC};
            lane_data <= state == SYNC    ? 16'hB8B8 :
                         state == HDR0    ? {wc[7:0], di} :
                         state == HDR1    ? {ecc, wc[15:8]} :
                         state == PAYLOAD ? beat :
                         state == CRC     ? crc : 16'h0000;
            underrun  <= state == PAYLOAD && !pix_valid;
            // Falls once the FE header has left the lanes
            frame_act <= (state == SYNC && pkt == PKT_FS) || (frame_act && !(state == GAP && pkt == PKT_FE));
            case (state)
                IDLE: if (enable) begin
                    state     <= SYNC;
                    pkt       <= PKT_FS;
                    line_cnt  <= '0;
                    frame_num <= frame_inc;
                end
                SYNC: state <= HDR0;
                HDR0: state <= HDR1;
                HDR1: begin
                    state <= pkt == PKT_LINE ? PAYLOAD : GAP;
                    cnt   <= '0;
                    crc   <= 16'hFFFF;
                end
                PAYLOAD: begin
                    cnt <= cnt + 16'd1;
                    crc <= crc_next;
                    if (cnt == LAST_BEAT) state <= CRC;
                end
                CRC: begin
                    state <= GAP;
                    cnt   <= '0;
                end
                GAP: begin
                    cnt <= cnt + 16'd1;
                    if (gap_done) begin
                        cnt <= '0;
                        if (pkt != PKT_FE) begin
                            state    <= SYNC;
                            pkt      <= pkt == PKT_LINE && line_cnt == LAST_LINE ? PKT_FE : PKT_LINE;
                            line_cnt <= pkt == PKT_LINE ? line_cnt + 16'd1 : '0;
                        end else if (enable) begin
                            state     <= SYNC;
                            pkt       <= PKT_FS;
                            line_cnt  <= '0;
                            frame_num <= frame_inc;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
